// File: rtl/radix2_divider_pkg.sv
// Shared constants for the radix-2 divider: operand width, div_op bit indices and the
// packed {HI, LO} result width.
package radix2_divider_pkg;

  localparam int unsigned DATA_WD         = 32;
  localparam int unsigned DIV_RES_WD      = 2 * DATA_WD;
  localparam int unsigned CNT_WD          = $clog2(DATA_WD);

  localparam int unsigned DIV_OP_SIGNED   = 0;
  localparam int unsigned DIV_OP_UNSIGNED = 1;

endpackage

// File: rtl/radix2_divider.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU; one result per request, held until taken.
// Result is packed {remainder, quotient} to map onto {HI, LO}.
module radix2_divider
  import radix2_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            div_op,
  input  logic [DATA_WD-1:0]    dividend,
  input  logic [DATA_WD-1:0]    divisor,
  input  logic                  div_in_valid,
  output logic                  div_in_ready,
  output logic [DIV_RES_WD-1:0] div_result,
  output logic                  div_out_valid,
  input  logic                  div_out_ready
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DIV_RES_WD-1:0] r_result;
  logic [DATA_WD-1:0]    r_rem;
  logic [DATA_WD-1:0]    r_dvd;
  logic [DATA_WD-1:0]    r_dsr;
  logic [CNT_WD-1:0]     r_cnt;
  logic                  r_q_neg;
  logic                  r_r_neg;

  logic                  w_accept;
  logic                  w_signed;
  logic                  w_dividend_neg;
  logic                  w_divisor_neg;
  logic [DATA_WD-1:0]    w_dividend_abs;
  logic [DATA_WD-1:0]    w_divisor_abs;
  logic [DATA_WD:0]      w_shift;
  logic                  w_borrow;
  logic [DATA_WD-1:0]    w_diff;
  logic                  w_trial_ok;
  logic [DATA_WD-1:0]    w_rem_next;
  logic [DATA_WD-1:0]    w_quo_next;
  logic [DATA_WD-1:0]    w_rem_fix;
  logic [DATA_WD-1:0]    w_quo_fix;
  logic                  w_last;

  assign w_accept = (r_state == StIdle) && r_in_ready && div_in_valid && (div_op != 2'b00);

  // Signed wins when both op bits are set; abs is a plain 32-bit negate so 0x8000_0000 survives.
  assign w_signed       = div_op[DIV_OP_SIGNED];
  assign w_dividend_neg = w_signed && dividend[DATA_WD-1];
  assign w_divisor_neg  = w_signed && divisor[DATA_WD-1];
  assign w_dividend_abs = w_dividend_neg ? -dividend : dividend;
  assign w_divisor_abs  = w_divisor_neg ? -divisor : divisor;

  // Shifted partial remainder is DATA_WD+1 bits; a set top bit always exceeds the divisor.
  assign w_shift              = {r_rem, r_dvd[DATA_WD-1]};
  assign {w_borrow, w_diff}   = {1'b0, w_shift[DATA_WD-1:0]} - {1'b0, r_dsr};
  assign w_trial_ok           = w_shift[DATA_WD] || !w_borrow;
  assign w_rem_next           = w_trial_ok ? w_diff : w_shift[DATA_WD-1:0];
  assign w_quo_next           = {r_dvd[DATA_WD-2:0], w_trial_ok};

  assign w_rem_fix = r_r_neg ? -w_rem_next : w_rem_next;
  assign w_quo_fix = r_q_neg ? -w_quo_next : w_quo_next;
  assign w_last    = (r_cnt == CNT_WD'(DATA_WD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= StBusy;
            r_in_ready <= 1'b0;
            r_dvd      <= w_dividend_abs;
            r_dsr      <= w_divisor_abs;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_q_neg    <= w_dividend_neg ^ w_divisor_neg;
            r_r_neg    <= w_dividend_neg;
          end
        end
        StBusy: begin
          r_rem <= w_rem_next;
          r_dvd <= w_quo_next;
          r_cnt <= r_cnt + CNT_WD'(1);
          if (w_last) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_result    <= {w_rem_fix, w_quo_fix};
          end
        end
        StDone: begin
          // ready stays low here so the next accept lands one cycle after returning to idle
          if (div_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign div_in_ready  = r_in_ready;
  assign div_out_valid = r_out_valid;
  assign div_result    = r_result;

endmodule

// File: tb/tb_radix2_divider.sv
// Scoreboard bench for radix2_divider: the driver queues expected results, a negedge monitor
// checks latency on each result and compares it at its handshake.
module tb_radix2_divider;

  logic        clk;
  logic        reset;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_in_valid;
  logic        div_in_ready;
  logic [63:0] div_result;
  logic        div_out_valid;
  logic        div_out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] exp_q[$];
  int          acc_q[$];

  radix2_divider dut (
    .clk           (clk),
    .reset         (reset),
    .div_op        (div_op),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_in_valid  (div_in_valid),
    .div_in_ready  (div_in_ready),
    .div_result    (div_result),
    .div_out_valid (div_out_valid),
    .div_out_ready (div_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: latency on each rising result, scoreboard compare at each handshake.
  initial begin
    logic        prev_v;
    logic [63:0] e;
    int          t0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (div_in_valid && div_in_ready && div_op != 2'b00) acc_q.push_back(cyc);
        if (div_out_valid && !prev_v) begin
          if (acc_q.size() == 0) begin
            chk("latency_no_accept", 64'd1, 64'd0);
          end else begin
            t0 = acc_q.pop_front();
            chk("latency", 64'(cyc - t0), 64'd33);
          end
        end
        if (div_out_valid && div_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", div_result, 64'hx);
          end else begin
            e = exp_q.pop_front();
            chk("result", div_result, e);
          end
        end
        prev_v = div_out_valid;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!div_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!div_in_ready) chk("accept_timeout", {63'd0, div_in_ready}, 64'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
    div_op       = op;
    dividend     = a;
    divisor      = b;
    div_in_valid = 1'b1;
    wait_ready();
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    div_in_valid = 1'b0;
    div_op       = 2'b00;
    dividend     = $urandom;
    divisor      = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    reset         = 1'b1;
    div_op        = 2'b00;
    dividend      = '0;
    divisor       = '0;
    div_in_valid  = 1'b0;
    div_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {63'd0, div_in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, div_out_valid}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {63'd0, div_in_ready}, 64'd1);
    @(posedge clk);
    #1;

    send(2'b10, 32'd100, 32'd7, {32'd2, 32'd14});
    drain();
    send(2'b01, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drain();
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    send(2'b10, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF});
    send(2'b10, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF});
    send(2'b01, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h1});
    send(2'b11, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    send(2'b10, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC});
    drain();

    // op 00 with valid high must not be accepted
    div_op       = 2'b00;
    dividend     = 32'd77;
    divisor      = 32'd3;
    div_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_op_no_accept", {63'd0, div_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    div_in_valid = 1'b0;

    // Backpressure: result held while a new request waits
    div_out_ready = 1'b0;
    send(2'b10, 32'd1000, 32'd10, {32'd0, 32'd100});
    seen = 0;
    while (!div_out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    div_op       = 2'b01;
    dividend     = 32'hFFFF_FF9C;
    divisor      = 32'd7;
    div_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {div_out_valid, div_in_ready, div_result[61:0]},
          {1'b1, 1'b0, 62'd100});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    div_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_early_accept", {62'd0, div_out_valid, div_in_ready}, 64'd0);
    exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
    @(negedge clk);
    chk("bp_accept_next", {63'd0, div_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    div_in_valid = 1'b0;
    div_op       = 2'b00;
    drain();

    // Reset mid-BUSY discards the request
    div_op       = 2'b10;
    dividend     = 32'd50;
    divisor      = 32'd5;
    div_in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    div_in_valid = 1'b0;
    div_op       = 2'b00;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_q.delete();
    @(negedge clk);
    chk("rst_busy_out_valid", {63'd0, div_out_valid}, 64'd0);
    @(negedge clk);
    chk("rst_busy_ready", {63'd0, div_in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_out_valid) seen++;
      @(negedge clk);
    end
    chk("rst_busy_no_result", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(2'b10, 32'd9, 32'd3, {32'd0, 32'd3});
    drain();

    chk("scoreboard_empty", 64'(exp_q.size() + acc_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
